sap_cpu: RTL and testbench
==========================

Name: sap_cpu

Overview:
Parametrised successor to the 8-bit bus-based computer core: accumulator CPU with A/B registers, ALU, PC, MAR, IR, internal RAM and output register. Uses a multiplexed internal bus (no tristates) and a fixed 5-step microsequencer. Adds carry/zero flags, conditional jumps (JC/JZ), an output-valid strobe, and a program-load port. Sits at top level under the clock/halt logic; the display driver consumes out_data/out_valid.

Parameters:
DATA_W, 8, datapath/RAM word width; must be >= ADDR_W+4
ADDR_W, 4, address width; RAM depth = 2**ADDR_W, PC/MAR width
OP_W, 4, opcode width = IR[DATA_W-1 -: OP_W]

Ports:
clk  in  1  system clock, single domain
rst  in  1  reset, asynchronous, active-high
run  in  1  1 = sequencer advances; 0 = step counter and all CPU regs hold
prog_we  in  1  RAM write strobe from loader; honoured only while run=0
prog_addr  in  ADDR_W  loader address
prog_data  in  DATA_W  loader data
out_data  out  DATA_W  output register
out_valid  out  1  one-cycle pulse when out_data updated
halted  out  1  sticky, set by HLT
pc  out  ADDR_W  current program counter (debug)

Behaviour:
- Reset (async): PC, MAR, IR, A, B, CF, ZF, out_data, out_valid, halted = 0; step = T0. RAM contents not cleared.
- RAM: asynchronous read of RAM[MAR]; synchronous write.
- Instruction format: opcode = top OP_W bits, operand = IR[ADDR_W-1:0]. Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; all others execute as NOP.
- Every instruction takes exactly 5 cycles (T0..T4) while run=1 and halted=0; unused steps idle; step wraps T4->T0.
- T0: MAR<=PC.
- T1: IR<=RAM[MAR]; PC<=PC+1, modulo 2**ADDR_W (15 -> 0 at default).
- T2: LDA/ADD/SUB/STA: MAR<=operand. LDI: A<=zero-extended operand. JMP: PC<=operand. JC: PC<=operand iff CF. JZ: PC<=operand iff ZF. OUT: out_data<=A, out_valid=1 for the next cycle only. HLT: halted<=1.
- T3: LDA: A<=RAM[MAR]. ADD/SUB: B<=RAM[MAR]. STA: RAM[MAR]<=A.
- T4: ADD: {CF,A}<=A+B. SUB: A<=A+~B+1; CF = carry-out (1 = no borrow). ZF<=(result==0). Flags change only in ADD/SUB T4.
- halted=1: step, PC and all regs freeze; only rst clears halted.
- run=0: sequencer frozen mid-instruction; resumes at the same step when run returns to 1.
- prog_we with run=1: ignored, no RAM write. prog_we with run=0 and halted=1: write allowed.
- STA and prog_we never coincide (STA requires run=1).
- out_valid is 0 in every cycle except the one following OUT T2.

Decomposition:
- Package sap_pkg: opcode localparams, step encoding (T0..T4 as 3-bit enum), DATA_W/ADDR_W legality check.
- Sub-module sap_alu: combinational DATA_W adder/subtractor producing result, carry, zero.
- Sequencer, control decode, bus mux and RAM stay in sap_cpu.

Test Plan:
- Add: RAM {0:0x1E,1:0x2F,2:0xE0,3:0xF0,14:0x0E,15:0x1C}, rst, run=1 -> single out_valid pulse with out_data=0x2A in cycle 13 after run; halted=1 by cycle 18; pc=4 thereafter.
- Subtract borrow: A=0x05 (LDI 5), SUB mem=0x07 -> A=0xFE, CF=0, ZF=0; SUB equal 3-3 -> A=0, CF=1, ZF=1.
- Conditional jumps: ADD 0xFF+0x01 -> A=0, CF=1, ZF=1; following JC 9 -> pc=9; after ADD 1+1 (CF=0, ZF=0), JC 9 and JZ 9 not taken -> pc increments.
- PC wrap: NOP at all 16 locations -> pc sequence 0..15 then 0; no out_valid, halted stays 0.
- Run/load gating: prog_we with run=1 -> RAM unchanged; drop run mid-T2 for 7 cycles -> all regs hold, instruction completes correctly after resume.
- Async reset mid-instruction (during ADD T3) -> all outputs 0 immediately without clock edge; RAM program intact; re-run gives identical results.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the sap_cpu accumulator core.
//   - default datapath widths
//   - opcode values (held 32 bits wide so they compare cleanly against any OP_W)
//   - microsequencer step encoding and internal bus source select
//   - width legality helper used at elaboration time
package sap_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_OP_W   = 4;

    localparam logic [31:0] OP_NOP = 32'h0;
    localparam logic [31:0] OP_LDA = 32'h1;
    localparam logic [31:0] OP_ADD = 32'h2;
    localparam logic [31:0] OP_SUB = 32'h3;
    localparam logic [31:0] OP_STA = 32'h4;
    localparam logic [31:0] OP_LDI = 32'h5;
    localparam logic [31:0] OP_JMP = 32'h6;
    localparam logic [31:0] OP_JC  = 32'h7;
    localparam logic [31:0] OP_JZ  = 32'h8;
    localparam logic [31:0] OP_OUT = 32'hE;
    localparam logic [31:0] OP_HLT = 32'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_RAM  = 3'd2,
        BUS_IR   = 3'd3,
        BUS_A    = 3'd4,
        BUS_ALU  = 3'd5
    } bus_sel_t;

    // Opcode and operand fields must not overlap inside one data word.
    function automatic bit widths_ok(int data_w, int addr_w, int op_w);
        return (data_w >= addr_w + 4) && (data_w >= addr_w + op_w) && (op_w <= 32);
    endfunction

endpackage

// File: rtl/sap_if.sv
// sap_if: control/load/output bundle of the sap_cpu core.
//   run                : sequencer enable
//   prog_we/addr/data  : RAM loader port (only honoured while run=0)
//   out_data/out_valid : output register and its one-cycle update strobe
//   halted, pc         : status / debug
// master = surrounding system (loader, clock/halt logic), slave = the CPU.
interface sap_if import sap_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic [ADDR_W-1:0] pc;

    modport master (
        output run, prog_we, prog_addr, prog_data,
        input  out_data, out_valid, halted, pc
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_data,
        output out_data, out_valid, halted, pc
    );
endinterface

// File: rtl/sap_alu.sv
// sap_alu: combinational adder/subtractor.
//   a, b   : operands
//   sub    : 0 = a+b, 1 = a+~b+1
//   result : low DATA_W bits of the sum
//   carry  : carry-out (for subtraction 1 means no borrow)
//   zero   : result == 0
module sap_alu import sap_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    assign b_eff  = sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
    assign result = sum[DATA_W-1:0];
    assign carry  = sum[DATA_W];
    assign zero   = (sum[DATA_W-1:0] == '0);
endmodule

// File: rtl/sap_cpu.sv
// sap_cpu: accumulator CPU with a multiplexed internal bus and a fixed
// five-step microsequencer (T0..T4, every instruction takes all five).
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : sap_if slave (run, loader port, output register, status)
// RAM is read asynchronously at MAR and written on the clock edge, either by
// STA (run=1) or by the loader (run=0); it is never cleared by reset.
module sap_cpu import sap_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OP_W   = DEF_OP_W
) (
    input logic   clk,
    input logic   rst,
    sap_if.slave  bus
);
    if (!widths_ok(DATA_W, ADDR_W, OP_W)) begin : g_bad_widths
        $error("sap_cpu: DATA_W too narrow for opcode plus operand");
    end

    step_t             step, step_next;
    bus_sel_t          bus_sel;
    logic [DATA_W-1:0] dbus;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] ram_rd, ir, a, b, out_r, alu_res;
    logic [ADDR_W-1:0] pc_r, mar;
    logic [31:0]       op;
    logic              cf, zf, out_v, halted_r, advance, alu_c, alu_z;
    logic              mar_ld, ir_ld, pc_inc, pc_ld, a_ld, b_ld;
    logic              out_ld, ram_we, flags_ld, hlt, alu_sub;

    assign advance = bus.run && !halted_r;
    assign ram_rd  = mem[mar];
    assign op      = {{(32-OP_W){1'b0}}, ir[DATA_W-1 -: OP_W]};

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a(a), .b(b), .sub(alu_sub),
        .result(alu_res), .carry(alu_c), .zero(alu_z)
    );

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step <= T0;
        else if (advance)
            step <= step_next;
    end

    // Sequencer next state: fixed T0..T4 ring
    always_comb begin
        step_next = T0;
        case (step)
            T0:      step_next = T1;
            T1:      step_next = T2;
            T2:      step_next = T3;
            T3:      step_next = T4;
            default: step_next = T0;
        endcase
    end

    // Control decode: one bus source and a set of load enables per step.
    // Nothing is enabled while frozen (run=0 or halted).
    always_comb begin
        bus_sel  = BUS_NONE;
        mar_ld   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        out_ld   = 1'b0;
        ram_we   = 1'b0;
        flags_ld = 1'b0;
        hlt      = 1'b0;
        alu_sub  = (op == OP_SUB);
        if (advance) begin
            case (step)
                T0: begin bus_sel = BUS_PC;  mar_ld = 1'b1; end
                T1: begin bus_sel = BUS_RAM; ir_ld = 1'b1; pc_inc = 1'b1; end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin bus_sel = BUS_IR; mar_ld = 1'b1; end
                        OP_LDI: begin bus_sel = BUS_IR; a_ld  = 1'b1; end
                        OP_JMP: begin bus_sel = BUS_IR; pc_ld = 1'b1; end
                        OP_JC:  begin bus_sel = BUS_IR; pc_ld = cf; end
                        OP_JZ:  begin bus_sel = BUS_IR; pc_ld = zf; end
                        OP_OUT: begin bus_sel = BUS_A;  out_ld = 1'b1; end
                        OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA:         begin bus_sel = BUS_RAM; a_ld = 1'b1; end
                        OP_ADD, OP_SUB: begin bus_sel = BUS_RAM; b_ld = 1'b1; end
                        OP_STA:         begin bus_sel = BUS_A;   ram_we = 1'b1; end
                        default: ;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        bus_sel  = BUS_ALU;
                        a_ld     = 1'b1;
                        flags_ld = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Internal bus mux; narrower sources are zero-extended
    always_comb begin
        case (bus_sel)
            BUS_PC:  dbus = {{(DATA_W-ADDR_W){1'b0}}, pc_r};
            BUS_RAM: dbus = ram_rd;
            BUS_IR:  dbus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
            BUS_A:   dbus = a;
            BUS_ALU: dbus = alu_res;
            default: dbus = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r     <= '0;
            mar      <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            cf       <= 1'b0;
            zf       <= 1'b0;
            out_r    <= '0;
            out_v    <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            out_v <= out_ld;
            if (mar_ld) mar <= dbus[ADDR_W-1:0];
            if (ir_ld)  ir  <= dbus;
            if (pc_ld)
                pc_r <= dbus[ADDR_W-1:0];
            else if (pc_inc)
                pc_r <= pc_r + ADDR_W'(1);
            if (a_ld)   a   <= dbus;
            if (b_ld)   b   <= dbus;
            if (flags_ld) begin
                cf <= alu_c;
                zf <= alu_z;
            end
            if (out_ld) out_r <= dbus;
            if (hlt)    halted_r <= 1'b1;
        end
    end

    // RAM: STA and loader writes are mutually exclusive through run
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[mar] <= dbus;
        else if (bus.prog_we && !bus.run)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    assign bus.out_data  = out_r;
    assign bus.out_valid = out_v;
    assign bus.halted    = halted_r;
    assign bus.pc        = pc_r;
endmodule

// File: tb/tb_sap_cpu.sv
module tb_sap_cpu;
    logic clk = 1'b0;
    logic rst;

    sap_if bus ();
    sap_cpu dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] img [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse consumes one expected out_data value
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("sb_out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic fill(input logic [7:0] v);
        foreach (img[i]) img[i] = v;
    endtask

    task automatic load();
        bus.run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'(i);
            bus.prog_data = img[i];
            @(negedge clk);
        end
        bus.prog_we = 1'b0;
    endtask

    task automatic do_reset();
        bus.run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_until_halt(input int max, input string tag);
        int n = 0;
        bus.run = 1'b1;
        while (bus.halted !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, 32'(bus.halted), 32'd1);
    endtask

    task automatic add_image();
        fill(8'h00);
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'h0E; img[15] = 8'h1C;
    endtask

    initial begin
        rst = 1'b1;
        bus.run = 1'b0;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        @(negedge clk);
        check("reset_pc", 32'(bus.pc), 32'h0);
        check("reset_out_data", 32'(bus.out_data), 32'h0);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_halted", 32'(bus.halted), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Add program with exact output and halt timing
        add_image();
        load();
        exp_q.push_back(8'h2A);
        bus.run = 1'b1;
        cycles(12);
        check("add_ov_c12", 32'(bus.out_valid), 32'd0);
        cycles(1);
        check("add_ov_c13", 32'(bus.out_valid), 32'd1);
        check("add_data_c13", 32'(bus.out_data), 32'h2A);
        cycles(4);
        check("add_halted_c17", 32'(bus.halted), 32'd0);
        cycles(1);
        check("add_halted_c18", 32'(bus.halted), 32'd1);
        check("add_pc_c18", 32'(bus.pc), 32'd4);
        cycles(5);
        check("add_pc_frozen", 32'(bus.pc), 32'd4);
        check("add_drain", 32'(exp_q.size()), 32'd0);

        // SUB with borrow: 5-7 = 0xFE, CF=0, ZF=0 -> JC and JZ fall through
        do_reset();
        fill(8'hF0);
        img[0] = 8'h55; img[1] = 8'h3E; img[2] = 8'hE0; img[3] = 8'h77;
        img[4] = 8'h88; img[5] = 8'hF0; img[14] = 8'h07;
        load();
        exp_q.push_back(8'hFE);
        run_until_halt(80, "sub_borrow");
        check("sub_borrow_pc", 32'(bus.pc), 32'd6);
        check("sub_borrow_drain", 32'(exp_q.size()), 32'd0);

        // SUB equal: 3-3 = 0, CF=1, ZF=1 -> JC 7 then JZ 10 taken
        do_reset();
        fill(8'hF0);
        img[0] = 8'h53; img[1] = 8'h3E; img[2] = 8'hE0; img[3] = 8'h77;
        img[7] = 8'h8A; img[10] = 8'hF0; img[14] = 8'h03;
        load();
        exp_q.push_back(8'h00);
        run_until_halt(80, "sub_equal");
        check("sub_equal_pc", 32'(bus.pc), 32'd11);
        check("sub_equal_drain", 32'(exp_q.size()), 32'd0);

        // ADD overflow 0xFF+1: A=0, CF=1, ZF=1 -> JC 9, JZ 12
        do_reset();
        fill(8'hF0);
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h79; img[9] = 8'hE0;
        img[10] = 8'h8C; img[12] = 8'hF0; img[14] = 8'hFF; img[15] = 8'h01;
        load();
        exp_q.push_back(8'h00);
        run_until_halt(80, "add_ovf");
        check("add_ovf_pc", 32'(bus.pc), 32'd13);
        check("add_ovf_drain", 32'(exp_q.size()), 32'd0);

        // ADD 1+1: CF=0, ZF=0 -> JC 9 and JZ 9 not taken
        do_reset();
        fill(8'hF0);
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h79; img[3] = 8'h89;
        img[4] = 8'hE0; img[5] = 8'hF0; img[14] = 8'h01; img[15] = 8'h01;
        load();
        exp_q.push_back(8'h02);
        run_until_halt(80, "jmp_not_taken");
        check("jmp_not_taken_pc", 32'(bus.pc), 32'd6);
        check("jmp_not_taken_drain", 32'(exp_q.size()), 32'd0);

        // PC wrap over 16 NOPs
        do_reset();
        fill(8'h00);
        load();
        bus.run = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cycles(5);
            check($sformatf("wrap_pc_%0d", k), 32'(bus.pc), 32'(k % 16));
        end
        check("wrap_halted", 32'(bus.halted), 32'd0);
        bus.run = 1'b0;
        check("wrap_drain", 32'(exp_q.size()), 32'd0);

        // Loader ignored while running; run dropped during ADD T2
        do_reset();
        add_image();
        load();
        exp_q.push_back(8'h2A);
        bus.run = 1'b1;
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'd14;
        bus.prog_data = 8'h55;
        cycles(2);
        bus.prog_we = 1'b0;
        cycles(5);
        bus.run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycles(1);
            check("hold_pc", 32'(bus.pc), 32'd2);
            check("hold_out_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.run = 1'b1;
        cycles(5);
        check("resume_ov_early", 32'(bus.out_valid), 32'd0);
        cycles(1);
        check("resume_ov", 32'(bus.out_valid), 32'd1);
        check("resume_data", 32'(bus.out_data), 32'h2A);
        run_until_halt(40, "resume");
        check("resume_pc", 32'(bus.pc), 32'd4);

        // Loader write accepted while halted with run=0; survives reset
        bus.run = 1'b0;
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'd15;
        bus.prog_data = 8'h01;
        cycles(1);
        bus.prog_we = 1'b0;
        do_reset();
        exp_q.push_back(8'h0F);
        run_until_halt(40, "halted_load");
        check("halted_load_pc", 32'(bus.pc), 32'd4);
        check("halted_load_drain", 32'(exp_q.size()), 32'd0);

        // Async reset during ADD T3, then identical re-run
        do_reset();
        fill(8'hF0);
        img[0] = 8'h1E; img[1] = 8'hE0; img[2] = 8'h2F; img[3] = 8'hE0;
        img[4] = 8'hF0; img[14] = 8'h0E; img[15] = 8'h1C;
        load();
        exp_q.push_back(8'h0E);
        bus.run = 1'b1;
        cycles(13);
        check("pre_rst_pc", 32'(bus.pc), 32'd3);
        check("pre_rst_out", 32'(bus.out_data), 32'h0E);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", 32'(bus.pc), 32'd0);
        check("async_rst_out", 32'(bus.out_data), 32'd0);
        check("async_rst_ov", 32'(bus.out_valid), 32'd0);
        check("async_rst_halted", 32'(bus.halted), 32'd0);
        bus.run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(8'h0E);
        exp_q.push_back(8'h2A);
        run_until_halt(60, "rerun");
        check("rerun_pc", 32'(bus.pc), 32'd5);
        check("rerun_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
